branch_resolver: RTL
====================

# branch_resolver

Resolves conditional branches (RV32I B-type) in the EX stage. It releases the fetch stall that the branch hazard logic raises when a branch is decoded. It captures the branch operands, evaluates the condition, computes the target, and returns one resume pulse to the fetch side. The pulse carries either a taken redirect, a not-taken fall-through, or a fault indication. Sits between the ID/EX register and the PC/IF-ID enable logic; keeps taken/not-taken statistics.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported)
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- br_valid  in  1  ID/EX holds a B-type instruction this cycle
- br_funct3  in  3  branch funct3
- br_pc  in  XLEN  PC of the branch
- br_imm  in  XLEN  sign-extended B-immediate
- br_rs1  in  XLEN  rs1 value (already forwarded)
- br_rs2  in  XLEN  rs2 value (already forwarded)
- resume  out  1  one-cycle pulse: fetch may restart; PC and IF/ID enables re-asserted
- redirect  out  1  with resume: load PC from redirect_pc
- redirect_pc  out  XLEN  next PC (target if taken, br_pc+4 otherwise)
- misaligned  out  1  with resume: taken target not 4-byte aligned; no redirect
- illegal  out  1  with resume: funct3 is 010 or 011
- busy  out  1  branch captured, not yet resolved
- overlap_err  out  1  sticky: br_valid seen while busy
- taken_cnt  out  CNT_W  branches resolved taken
- ntaken_cnt  out  CNT_W  branches resolved not taken

## Operation
- FSM states: IDLE, EVAL.
- IDLE: when br_valid=1, latch funct3, pc, imm, rs1, rs2. Go to EVAL; busy=1.
- EVAL: always return to IDLE next edge. Register the result outputs at that edge.
- Conditions by funct3:
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed <
  - 101 BGE: signed >=
  - 110 BLTU: unsigned <
  - 111 BGEU: unsigned >=
  - 010/011: illegal=1, treated as not taken for redirect_pc; no counter increment.
- Target = pc + imm, modulo 2^XLEN (wrap, no overflow flag). Fall-through = pc + 4, also wrapping.
- Taken with target[1:0]!=0:
  - misaligned=1, redirect=0, redirect_pc=target for trap reporting.
  - Counts as taken.
- Taken and aligned: redirect=1, redirect_pc=target, taken_cnt++.
- Not taken: redirect=0, redirect_pc=pc+4, ntaken_cnt++.
- resume, redirect, misaligned and illegal are single-cycle pulses. redirect_pc holds its value until the next resolution.
- Counters wrap at 2^CNT_W-1 -> 0.
- br_valid while busy (EVAL): ignored, not captured, overlap_err set. overlap_err clears only on rst.
- br_valid in the same cycle resume is high (state IDLE): captured normally. Back-to-back branches are therefore resolved every 2 cycles.

## Timing
- Reset (rst=1 at an edge) forces the following, regardless of current state; an in-flight branch is dropped with no resume pulse:
  - state=IDLE
  - busy=0, resume=0, redirect=0, misaligned=0, illegal=0
  - redirect_pc=0, overlap_err=0, taken_cnt=0, ntaken_cnt=0
- br_valid sampled at edge E0. busy=1 during the cycle after E0.
- At edge E1 the result outputs register. resume and the flags are high for exactly the cycle after E1, and busy=0 in that cycle.
- Latency br_valid -> resume: 2 edges. Counters update at E1, visible in the same cycle as resume.
- All outputs registered; no combinational path from inputs to outputs.
- Inputs only need to be valid in the cycle br_valid=1.

## Test plan
- Reset: assert rst mid-EVAL with a taken BEQ in flight. Required: no resume pulse; all outputs 0 the cycle after the rst edge.
- BEQ taken: pc=0x100, imm=0x20, rs1=rs2=5. Required: 2 edges later resume=1, redirect=1, redirect_pc=0x120, taken_cnt=1.
- BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=-8.
  - BLT taken: redirect_pc=0x1F8.
  - BLTU not taken: redirect=0, redirect_pc=0x204, ntaken_cnt=1.
- Misaligned: BNE, rs1=1, rs2=2, pc=0x300, imm=0x6. Required: resume=1, misaligned=1, redirect=0, redirect_pc=0x306.
- Wrap and illegal cases:
  - pc=0xFFFFFFFC, imm=0x8, BGEU with 3>=3. Required: redirect_pc=0x00000004.
  - funct3=010. Required: illegal=1, redirect_pc=pc+4, counters unchanged.
- Overlap/back-to-back:
  - br_valid held for 3 consecutive cycles. Required: overlap_err=1 after the 2nd; first branch resolves normally; 3rd (coincides with resume) is captured and resolves 2 edges later.
  - Preload taken_cnt to 0xFFFFFFFF via 2^32-1 forced value, then one taken branch. Required: taken_cnt=0.

Source files
------------

// File: rtl/branch_resolver.sv
// EX-stage resolver for RV32I conditional branches: captures operands, evaluates
// the condition one cycle later and returns a single registered resume pulse.
module branch_resolver #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   input  logic [2:0]       br_funct3,
   input  logic [XLEN-1:0]  br_pc,
   input  logic [XLEN-1:0]  br_imm,
   input  logic [XLEN-1:0]  br_rs1,
   input  logic [XLEN-1:0]  br_rs2,
   output logic             resume,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             misaligned,
   output logic             illegal,
   output logic             busy,
   output logic             overlap_err,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] ntaken_cnt
);

   typedef enum logic {IDLE, EVAL} state_t;

   state_t            state;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   imm_q;
   logic [XLEN-1:0]   rs1_q;
   logic [XLEN-1:0]   rs2_q;

   logic              cond;
   logic              is_illegal;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   fall_through;

   // Condition and both candidate PCs come only from the captured operands,
   // so nothing on the input ports reaches an output without a register.
   always_comb begin
      cond       = 1'b0;
      is_illegal = 1'b0;
      case (funct3_q)
         3'b000:  cond = (rs1_q == rs2_q);
         3'b001:  cond = (rs1_q != rs2_q);
         3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
         3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
         3'b110:  cond = (rs1_q <  rs2_q);
         3'b111:  cond = (rs1_q >= rs2_q);
         default: is_illegal = 1'b1;
      endcase
      target       = pc_q + imm_q;
      fall_through = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         funct3_q    <= 3'b000;
         pc_q        <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         resume      <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         misaligned  <= 1'b0;
         illegal     <= 1'b0;
         busy        <= 1'b0;
         overlap_err <= 1'b0;
         taken_cnt   <= '0;
         ntaken_cnt  <= '0;
      end else begin
         resume     <= 1'b0;
         redirect   <= 1'b0;
         misaligned <= 1'b0;
         illegal    <= 1'b0;
         case (state)
            IDLE: begin
               if (br_valid) begin
                  funct3_q <= br_funct3;
                  pc_q     <= br_pc;
                  imm_q    <= br_imm;
                  rs1_q    <= br_rs1;
                  rs2_q    <= br_rs2;
                  busy     <= 1'b1;
                  state    <= EVAL;
               end
            end
            EVAL: begin
               state  <= IDLE;
               busy   <= 1'b0;
               resume <= 1'b1;
               if (br_valid) begin
                  overlap_err <= 1'b1;
               end
               if (is_illegal) begin
                  illegal     <= 1'b1;
                  redirect_pc <= fall_through;
               end else if (cond) begin
                  // A misaligned taken target still reports the target for the trap.
                  redirect_pc <= target;
                  taken_cnt   <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (target[1:0] != 2'b00) begin
                     misaligned <= 1'b1;
                  end else begin
                     redirect <= 1'b1;
                  end
               end else begin
                  redirect_pc <= fall_through;
                  ntaken_cnt  <= ntaken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
